// File: rtl/rv32i_exec_mem.sv
// ============================================================================
// rv32i_exec_mem : RV32I execute/memory slice (immediate gen, ALU, data RAM)
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32i_exec_mem #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [2:0]  imm_sel,
    output logic [31:0] immediate,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_sel,
    output logic [31:0] alu_result,
    input  logic [31:0] mem_wdata,
    input  logic        mem_rw,
    output logic [31:0] mem_rdata
);

    localparam int C_AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] C_IMM_I = 3'd0;
    localparam logic [2:0] C_IMM_S = 3'd1;
    localparam logic [2:0] C_IMM_B = 3'd2;
    localparam logic [2:0] C_IMM_U = 3'd3;
    localparam logic [2:0] C_IMM_J = 3'd4;

    localparam logic [3:0] C_ALU_ADD  = 4'd0;
    localparam logic [3:0] C_ALU_SUB  = 4'd1;
    localparam logic [3:0] C_ALU_SLL  = 4'd2;
    localparam logic [3:0] C_ALU_SLT  = 4'd3;
    localparam logic [3:0] C_ALU_SLTU = 4'd4;
    localparam logic [3:0] C_ALU_XOR  = 4'd5;
    localparam logic [3:0] C_ALU_SRL  = 4'd6;
    localparam logic [3:0] C_ALU_SRA  = 4'd7;
    localparam logic [3:0] C_ALU_OR   = 4'd8;
    localparam logic [3:0] C_ALU_AND  = 4'd9;
    localparam logic [3:0] C_ALU_PASS = 4'd10;

    logic [31:0]     mem_q [MEM_DEPTH];
    logic [C_AW-1:0] w_word_idx;
    logic [4:0]      w_shamt;
    logic            w_unused_opcode;

    // The opcode field carries no immediate bits in any format.
    assign w_unused_opcode = ^instr[6:0];

    always_comb begin
        immediate = 32'd0;
        case (imm_sel)
            C_IMM_I: immediate = {{20{instr[31]}}, instr[31:20]};
            C_IMM_S: immediate = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            C_IMM_B: immediate = {{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
            C_IMM_U: immediate = {instr[31:12], 12'd0};
            C_IMM_J: immediate = {{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0};
            default: immediate = 32'd0;
        endcase
    end

    assign w_shamt = alu_b[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (alu_sel)
            C_ALU_ADD:  alu_result = alu_a + alu_b;
            C_ALU_SUB:  alu_result = alu_a - alu_b;
            C_ALU_SLL:  alu_result = alu_a << w_shamt;
            C_ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            C_ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
            C_ALU_XOR:  alu_result = alu_a ^ alu_b;
            C_ALU_SRL:  alu_result = alu_a >> w_shamt;
            C_ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> w_shamt);
            C_ALU_OR:   alu_result = alu_a | alu_b;
            C_ALU_AND:  alu_result = alu_a & alu_b;
            C_ALU_PASS: alu_result = alu_b;
            default:    alu_result = 32'd0;
        endcase
    end

    // Byte offset and bits above the array size are dropped: aligned, wrapping.
    assign w_word_idx = alu_result[C_AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_rw) begin
            mem_q[w_word_idx] <= mem_wdata;
        end
    end

    assign mem_rdata = rst ? 32'd0 : mem_q[w_word_idx];

endmodule

`default_nettype wire

// File: tb/tb_rv32i_exec_mem.sv
// ============================================================================
// tb_rv32i_exec_mem : directed self-checking bench for rv32i_exec_mem
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_exec_mem;

    localparam int C_DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic [31:0] immediate;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_errors;

    rv32i_exec_mem #(.MEM_DEPTH(C_DEPTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imm_sel    (imm_sel),
        .immediate  (immediate),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic imm(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [31:0] exp);
        instr   = ins;
        imm_sel = sel;
        #1;
        chk(tag, immediate, exp);
    endtask

    task automatic alu(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] sel, input logic [31:0] exp);
        alu_a   = a;
        alu_b   = b;
        alu_sel = sel;
        #1;
        chk(tag, alu_result, exp);
    endtask

    // Address via ADD with B=0, then check the read word.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        alu_a   = addr;
        alu_b   = 32'd0;
        alu_sel = 4'd0;
        #1;
        chk(tag, mem_rdata, exp);
    endtask

    // Single store at the next rising edge; returns 1 ns after it.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        alu_a     = addr;
        alu_b     = 32'd0;
        alu_sel   = 4'd0;
        mem_wdata = data;
        mem_rw    = 1'b1;
        @(posedge clk);
        #1;
        mem_rw    = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        instr     = 32'd0;
        imm_sel   = 3'd0;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_sel   = 4'd0;
        mem_wdata = 32'd0;
        mem_rw    = 1'b0;
        #2;
        rd("reset_rdata", 32'h0000_0000, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        rd("post_reset_rdata", 32'h0000_0108, 32'h0000_0000);

        imm("imm_i",     32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF);
        imm("imm_s",     32'h0011_2623, 3'd1, 32'h0000_000C);
        imm("imm_u",     32'h1234_50B7, 3'd3, 32'h1234_5000);
        imm("imm_b",     32'hFE00_0EE3, 3'd2, 32'hFFFF_FFFC);
        imm("imm_j",     32'hFFDF_F06F, 3'd4, 32'hFFFF_FFFC);
        imm("imm_sel5",  32'hFFDF_F06F, 3'd5, 32'h0000_0000);
        imm("imm_i_pos", 32'h7FF0_0093, 3'd0, 32'h0000_07FF);

        alu("add_wrap",  32'hFFFF_FFFF, 32'd1,  4'd0,  32'h0000_0000);
        alu("sub",       32'hFFFF_FFFF, 32'd1,  4'd1,  32'hFFFF_FFFE);
        alu("sra",       32'h8000_0000, 32'd4,  4'd7,  32'hF800_0000);
        alu("srl",       32'h8000_0000, 32'd4,  4'd6,  32'h0800_0000);
        alu("sll_b36",   32'h8000_0000, 32'd36, 4'd2,  32'h0000_0000);
        alu("sll",       32'h0000_0003, 32'd36, 4'd2,  32'h0000_0030);
        alu("slt",       32'hFFFF_FFFF, 32'd1,  4'd3,  32'h0000_0001);
        alu("sltu",      32'hFFFF_FFFF, 32'd1,  4'd4,  32'h0000_0000);
        alu("sltu_true", 32'h0000_0001, 32'hFFFF_FFFF, 4'd4, 32'h0000_0001);
        alu("xor",       32'hF0F0_1234, 32'h0FF0_FFFF, 4'd5, 32'hFF00_EDCB);
        alu("or",        32'hF0F0_1234, 32'h0FF0_FFFF, 4'd8, 32'hFFF0_FFFF);
        alu("and",       32'hF0F0_1234, 32'h0FF0_FFFF, 4'd9, 32'h00F0_1234);
        alu("pass_b",    32'hAAAA_AAAA, 32'h1234_5000, 4'd10, 32'h1234_5000);
        alu("sel11",     32'hAAAA_AAAA, 32'h1234_5000, 4'd11, 32'h0000_0000);

        // Store via A=0x100 + B=8.
        @(negedge clk);
        alu_a     = 32'h0000_0100;
        alu_b     = 32'd8;
        alu_sel   = 4'd0;
        mem_wdata = 32'hDEAD_BEEF;
        mem_rw    = 1'b1;
        #1;
        chk("store_addr", alu_result, 32'h0000_0108);
        @(posedge clk);
        #1;
        mem_rw = 1'b0;
        chk("store_load", mem_rdata, 32'hDEAD_BEEF);
        rd("low_bits_ignored", 32'h0000_010B, 32'hDEAD_BEEF);
        rd("addr_wrap", 32'h0000_0108 + 32'(4 * C_DEPTH), 32'hDEAD_BEEF);
        rd("neighbour_untouched", 32'h0000_010C, 32'h0000_0000);

        // Async reset between edges, with a write attempted while held.
        @(negedge clk);
        rd("pre_reset_hold", 32'h0000_0108, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        chk("reset_async", mem_rdata, 32'h0000_0000);
        alu_a     = 32'h0000_0040;
        mem_wdata = 32'h5555_5555;
        mem_rw    = 1'b1;
        @(posedge clk);
        #1;
        mem_rw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd("reset_cleared", 32'h0000_0108, 32'h0000_0000);
        rd("write_in_reset", 32'h0000_0040, 32'h0000_0000);

        // Read-during-write.
        wr(32'h0000_0020, 32'd5);
        @(negedge clk);
        alu_a     = 32'h0000_0020;
        alu_b     = 32'd0;
        alu_sel   = 4'd0;
        mem_wdata = 32'd9;
        mem_rw    = 1'b1;
        #1;
        chk("rdw_before", mem_rdata, 32'd5);
        @(posedge clk);
        #1;
        mem_rw = 1'b0;
        chk("rdw_after", mem_rdata, 32'd9);

        repeat (3) @(posedge clk);
        rd("persist", 32'h0000_0020, 32'd9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv32i_exec_mem.md
# rv32i_exec_mem

Execute/memory datapath slice of the single-cycle RV32I core: an immediate generator, a 32-bit integer ALU and a word-addressed data memory. The ALU result is the data-memory address. The controller, register file, PC logic and write-back mux are outside this block and drive the select inputs.

## Interface
Parameters:
- `MEM_DEPTH`, default 1024: data memory size in 32-bit words; must be a power of two.

Ports:
- `clk`  in  1  clock. Memory writes occur on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high. Clears the whole data memory.
- `instr`  in  32  current instruction, used only for immediate extraction.
- `imm_sel`  in  3  immediate format select.
- `immediate`  out  32  sign/zero-formatted immediate.
- `alu_a`  in  32  ALU operand A (rs1 or PC, muxed externally).
- `alu_b`  in  32  ALU operand B (rs2 or immediate, muxed externally).
- `alu_sel`  in  4  ALU operation select.
- `alu_result`  out  32  ALU result; also the data-memory byte address.
- `mem_wdata`  in  32  store data (rs2).
- `mem_rw`  in  1  1 = write `mem_wdata` at the next rising edge; 0 = read only.
- `mem_rdata`  out  32  word at `alu_result`.

## Operation
Immediate generator (purely combinational), selected by `imm_sel`:
- 0 I-type: sign-extend `instr[31:20]`.
- 1 S-type: sign-extend `{instr[31:25], instr[11:7]}`.
- 2 B-type: sign-extend `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
- 3 U-type: `{instr[31:12], 12'b0}`.
- 4 J-type: sign-extend `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- 5 to 7: output 0.

ALU (purely combinational), selected by `alu_sel`:
- 0 ADD, 1 SUB. Both wrap modulo 2^32; there is no carry or overflow output.
- 2 SLL, 6 SRL, 7 SRA. Shift amount is `alu_b[4:0]`; SRA replicates `alu_a[31]`.
- 3 SLT: signed compare, result 1 or 0.
- 4 SLTU: unsigned compare, result 1 or 0.
- 5 XOR, 8 OR, 9 AND.
- 10 PASS_B: result = `alu_b`. Used for LUI.
- 11 to 15: result 0.

Data memory:
- Storage is `MEM_DEPTH` words of 32 bits.
- Word index = `alu_result[log2(MEM_DEPTH)+1 : 2]`.
  - Bits [1:0] are ignored; accesses are always aligned full words.
  - Higher address bits are ignored, so addresses wrap modulo 4*`MEM_DEPTH`.
- Full-word stores only; there are no byte or halfword enables.
- Read is asynchronous: `mem_rdata` always reflects the currently addressed word.

## Timing
- Immediate and ALU paths: zero latency, combinational; no state.
- Memory write:
  - Occurs on the rising `clk` edge when `mem_rw`=1 and `rst`=0.
  - A read at the same address returns the old value before the edge and the new value after it.
  - One write per cycle.
- Reset:
  - Asserting `rst` immediately (asynchronously) clears all words to 0.
  - While `rst` is high, `mem_rdata`=0 and writes are suppressed.
  - Reset mid-operation discards any pending write of that cycle.
  - The first write after reset is taken at the first rising edge where `rst` is already low.
- Combinational outputs (`immediate`, `alu_result`) are unaffected by `rst`.
- Memory contents persist indefinitely with `mem_rw`=0.

## Test plan
- Immediates:
  - `instr`=0xFFF00093, `imm_sel`=0 -> `immediate`=0xFFFFFFFF.
  - `instr`=0x00112623 (sw x1,12(x2)), `imm_sel`=1 -> 0x0000000C.
  - `instr`=0x123450B7, `imm_sel`=3 -> 0x12345000.
  - `instr`=0xFE000EE3 (beq x0,x0,-4), `imm_sel`=2 -> 0xFFFFFFFC.
- ALU arithmetic and shifts:
  - A=0xFFFFFFFF, B=1: ADD -> 0; SUB -> 0xFFFFFFFE.
  - A=0x80000000, B=4: SRA -> 0xF8000000; SRL -> 0x08000000.
  - A=0x80000000, B=36 (uses shift amount 4): SLL -> 0.
- ALU compares: A=0xFFFFFFFF, B=1 -> SLT = 1, SLTU = 0. `alu_sel`=10 with B=0x12345000 -> 0x12345000.
- Memory store/load:
  - A=0x100, B=8, ADD, `mem_wdata`=0xDEADBEEF, `mem_rw`=1 for one edge -> `mem_rdata`=0xDEADBEEF after the edge.
  - Address 0x10B (same word as 0x108, low bits ignored) reads 0xDEADBEEF.
  - Address 0x108 + 4*`MEM_DEPTH` reads 0xDEADBEEF (wrap).
- Reset: after the store above, pulse `rst` between clock edges -> `mem_rdata` at 0x108 is 0 immediately. A write with `mem_rw`=1 while `rst`=1 is not retained.
- Read-during-write: address 0x20 holds 5, write 9 -> `mem_rdata`=5 before the edge, 9 after.
